// File: rtl/mul_sched.sv
// mul_sched: round-robin issue scheduler for the shared fixed-latency multiply unit.
// Build option: define MUL_SCHED_FP_EN to forward FP ops; otherwise FP ops raise exc_valid.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

module mul_sched #(
  parameter int N_REQ = 2,
  parameter int LAT   = 4,
  parameter int ROB_W = `LG_ROB_ENTRIES,
  parameter int PRF_W = `LG_PRF_ENTRIES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][6:0]              req_op,
  input  logic [N_REQ-1:0][`M_WIDTH-1:0]     req_src_a,
  input  logic [N_REQ-1:0][`M_WIDTH-1:0]     req_src_b,
  input  logic [N_REQ-1:0][ROB_W-1:0]        req_rob,
  input  logic [N_REQ-1:0][PRF_W-1:0]        req_prf,
  input  logic                               slot_resv,
  input  logic                               flush,
  output logic                               m_go,
  output logic                               m_is_signed,
  output logic                               m_is_high,
  output logic                               m_is_mulw,
  output logic                               m_fp_add,
  output logic                               m_fp_sub,
  output logic                               m_fp_mul,
  output logic [`M_WIDTH-1:0]                m_src_a,
  output logic [`M_WIDTH-1:0]                m_src_b,
  output logic [ROB_W-1:0]                   m_rob,
  output logic [PRF_W-1:0]                   m_prf,
  input  logic                               m_complete,
  output logic                               wb_valid,
  output logic                               exc_valid,
  output logic [ROB_W-1:0]                   exc_rob,
  output logic                               busy,
  output logic [$clog2(LAT+2)-1:0]           inflight_cnt
);

  localparam int RR_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LAT+2);

  logic [RR_W-1:0]      r_rr_ptr;
  logic [LAT:0]         r_sv;
  logic                 r_m_go;
  logic [2:0]           r_m_mode;
  logic [`M_WIDTH-1:0]  r_m_src_a;
  logic [`M_WIDTH-1:0]  r_m_src_b;
  logic [ROB_W-1:0]     r_m_rob;
  logic [PRF_W-1:0]     r_m_prf;
  logic                 r_exc_valid;
  logic [ROB_W-1:0]     r_exc_rob;

  logic [N_REQ-1:0]     w_elig;
  logic [N_REQ-1:0]     w_grant;
  logic [RR_W-1:0]      w_sel;
  logic [RR_W-1:0]      w_rr_next;
  logic [RR_W:0]        w_cand;
  logic                 w_found;
  logic [6:0]           w_op;
  logic [`M_WIDTH-1:0]  w_a;
  logic [`M_WIDTH-1:0]  w_b;
  logic [ROB_W-1:0]     w_rob;
  logic [PRF_W-1:0]     w_prf;
  logic                 w_is_fp;
  logic                 w_fwd;
  logic                 w_exc;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_unused;

  // Flush and reset both veto eligibility, so a same-cycle flush never produces a handshake.
  assign w_elig = req_valid & {N_REQ{~slot_resv & ~flush & reset}};

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
      if (w_cand >= (RR_W+1)'(N_REQ)) w_cand = w_cand - (RR_W+1)'(N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && w_elig[i] && (w_cand == (RR_W+1)'(i))) begin
          w_found = 1'b1;
          w_sel   = RR_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_op    = '0;
    w_a     = '0;
    w_b     = '0;
    w_rob   = '0;
    w_prf   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found && (w_sel == RR_W'(i))) begin
        w_grant[i] = 1'b1;
        w_op       = req_op[i];
        w_a        = req_src_a[i];
        w_b        = req_src_b[i];
        w_rob      = req_rob[i];
        w_prf      = req_prf[i];
      end
    end
  end

  assign req_ready = w_grant;
  assign w_rr_next = (w_sel == RR_W'(N_REQ-1)) ? '0 : w_sel + RR_W'(1);
  assign w_is_fp   = |w_op[3:1];

`ifdef MUL_SCHED_FP_EN
  assign w_fwd = w_found;
  assign w_exc = 1'b0;
`else
  assign w_fwd = w_found & ~w_is_fp;
  assign w_exc = w_found & w_is_fp;
`endif

  // Issue stage: register the granted op onto the multiplier inputs and the shadow vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_sv        <= '0;
      r_m_go      <= 1'b0;
      r_m_mode    <= '0;
      r_m_src_a   <= '0;
      r_m_src_b   <= '0;
      r_m_rob     <= '0;
      r_m_prf     <= '0;
      r_exc_valid <= 1'b0;
      r_exc_rob   <= '0;
    end else begin
      r_m_go      <= w_fwd;
      r_exc_valid <= w_exc;
      r_sv        <= flush ? '0 : {r_sv[LAT-1:0], w_fwd};
      if (w_found) r_rr_ptr <= w_rr_next;
      if (w_exc) r_exc_rob <= w_rob;
      if (w_fwd) begin
        r_m_mode  <= w_op[6:4];
        r_m_src_a <= w_a;
        r_m_src_b <= w_b;
        r_m_rob   <= w_rob;
        r_m_prf   <= w_prf;
      end
    end
  end

`ifdef MUL_SCHED_FP_EN
  logic [2:0] r_m_fp;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_m_fp <= '0;
    else if (w_fwd) r_m_fp <= w_op[3:1];
  end
  assign m_fp_add = r_m_fp[2];
  assign m_fp_sub = r_m_fp[1];
  assign m_fp_mul = r_m_fp[0];
`else
  assign m_fp_add = 1'b0;
  assign m_fp_sub = 1'b0;
  assign m_fp_mul = 1'b0;
`endif

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i <= LAT; i++) w_cnt = w_cnt + CNT_W'(r_sv[i]);
  end

  assign m_go         = r_m_go;
  assign m_is_signed  = r_m_mode[2];
  assign m_is_high    = r_m_mode[1];
  assign m_is_mulw    = r_m_mode[0];
  assign m_src_a      = r_m_src_a;
  assign m_src_b      = r_m_src_b;
  assign m_rob        = r_m_rob;
  assign m_prf        = r_m_prf;
  assign wb_valid     = m_complete & r_sv[LAT];
  assign exc_valid    = r_exc_valid;
  assign exc_rob      = r_exc_rob;
  assign busy         = |r_sv;
  assign inflight_cnt = w_cnt;
  assign w_unused     = ^{w_op[0], w_is_fp};

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched (N_REQ=2, LAT=4); follows MUL_SCHED_FP_EN if defined.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif

module tb_mul_sched;
  localparam int N   = 2;
  localparam int LAT = 4;
  localparam int RW  = 6;
  localparam int PW  = 7;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready;
  logic [N-1:0][6:0] req_op;
  logic [N-1:0][`M_WIDTH-1:0] req_src_a, req_src_b;
  logic [N-1:0][RW-1:0] req_rob;
  logic [N-1:0][PW-1:0] req_prf;
  logic slot_resv, flush, m_complete;
  logic m_go, m_is_signed, m_is_high, m_is_mulw, m_fp_add, m_fp_sub, m_fp_mul;
  logic [`M_WIDTH-1:0] m_src_a, m_src_b;
  logic [RW-1:0] m_rob, exc_rob;
  logic [PW-1:0] m_prf;
  logic wb_valid, exc_valid, busy;
  logic [2:0] inflight_cnt;

  int n_chk = 0;
  int n_err = 0;

  mul_sched #(.N_REQ(N), .LAT(LAT), .ROB_W(RW), .PRF_W(PW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b),
    .req_rob(req_rob), .req_prf(req_prf), .slot_resv(slot_resv), .flush(flush),
    .m_go(m_go), .m_is_signed(m_is_signed), .m_is_high(m_is_high), .m_is_mulw(m_is_mulw),
    .m_fp_add(m_fp_add), .m_fp_sub(m_fp_sub), .m_fp_mul(m_fp_mul),
    .m_src_a(m_src_a), .m_src_b(m_src_b), .m_rob(m_rob), .m_prf(m_prf),
    .m_complete(m_complete), .wb_valid(wb_valid), .exc_valid(exc_valid), .exc_rob(exc_rob),
    .busy(busy), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic       resv;
    logic       fl;
    logic [1:0] exp_ready;
    logic       exp_go;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 2'b11;
    req_op[0] = 7'h01; req_op[1] = 7'h01;
    req_src_a[0] = 64'h11; req_src_a[1] = 64'h22;
    req_src_b[0] = 64'h33; req_src_b[1] = 64'h44;
    req_rob[0] = 6'd1; req_rob[1] = 6'd2;
    req_prf[0] = 7'd3; req_prf[1] = 7'd4;
    slot_resv = 1'b0; flush = 1'b0; m_complete = 1'b0;

    // valid, resv, flush, exp_ready, exp_go, exp_cnt
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 3'd0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 3'd1};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 3'd2};
    vecs[3]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 3'd3};
    vecs[4]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 3'd4};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 3'd5};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 3'd5};
    vecs[7]  = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd4};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 3'd3};
    vecs[9]  = '{2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 3'd3};
    vecs[10] = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 3'd0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 3'd1};

    // reset state
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_go", m_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_rob", m_rob, 0);
    chk("rst_wb", wb_valid, 0);
    step(); step();
    req_valid = 2'b00;
    reset = 1'b1;

    // arbitration / slot reservation / flush table
    for (int r = 0; r < 12; r++) begin
      req_valid = vecs[r].valid;
      slot_resv = vecs[r].resv;
      flush = vecs[r].fl;
      #1;
      chk($sformatf("tbl%0d_ready", r), req_ready, vecs[r].exp_ready);
      chk($sformatf("tbl%0d_go", r), m_go, vecs[r].exp_go);
      chk($sformatf("tbl%0d_cnt", r), inflight_cnt, vecs[r].exp_cnt);
      step();
    end
    req_valid = 2'b00; slot_resv = 1'b0; flush = 1'b0;
    repeat (6) step();
    chk("idle_busy", busy, 0);

    // single signed int mul on req 0
    req_op[0] = 7'b1000001; req_rob[0] = 6'd5; req_prf[0] = 7'd9;
    req_src_a[0] = 64'h1234; req_src_b[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    req_valid = 2'b01;
    #1;
    chk("int_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("int_go", m_go, 1);
    chk("int_rob", m_rob, 5);
    chk("int_prf", m_prf, 9);
    chk("int_a", m_src_a, 64'h1234);
    chk("int_b", m_src_b, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("int_signed", m_is_signed, 1);
    chk("int_high", m_is_high, 0);
    step();
    chk("int_go_drop", m_go, 0);
    chk("int_rob_hold", m_rob, 5);
    step(); step();
    m_complete = 1'b1;
    #1;
    chk("int_wb_early", wb_valid, 0);
    step();
    chk("int_wb", wb_valid, 1);
    step();
    chk("int_wb_stale", wb_valid, 0);
    m_complete = 1'b0;

    // flush squashes in-flight ops and blocks the same-cycle request
    repeat (6) step();
    req_valid = 2'b10;
    #1; chk("fl_ready0", req_ready, 2'b10);
    step();
    #1; chk("fl_ready1", req_ready, 2'b10);
    step();
    flush = 1'b1;
    #1; chk("fl_ready2", req_ready, 2'b00);
    step();
    flush = 1'b0; req_valid = 2'b00;
    chk("fl_busy", busy, 0);
    chk("fl_cnt", inflight_cnt, 0);
    chk("fl_go", m_go, 0);
    m_complete = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("fl_wb%0d", c), wb_valid, 0);
      step();
    end
    m_complete = 1'b0;

    // asynchronous reset mid-burst
    req_valid = 2'b11;
    #1; chk("ar_ready", req_ready, 2'b01);
    step();
    chk("ar_go_pre", m_go, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_go", m_go, 0);
    chk("ar_ready0", req_ready, 2'b00);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", inflight_cnt, 0);
    chk("ar_rob", m_rob, 0);
    chk("ar_a", m_src_a, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("ar_first", req_ready, 2'b01);
    step();
    chk("ar_go_post", m_go, 1);
    chk("ar_cnt_post", inflight_cnt, 1);
    req_valid = 2'b00;
    repeat (6) step();

    // FP multiply on req 0
    req_op[0] = 7'b0000010; req_rob[0] = 6'd12;
    req_valid = 2'b01;
    #1; chk("fp_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
`ifdef MUL_SCHED_FP_EN
    chk("fp_go", m_go, 1);
    chk("fp_mul", m_fp_mul, 1);
    chk("fp_exc", exc_valid, 0);
    chk("fp_busy", busy, 1);
`else
    chk("fp_go", m_go, 0);
    chk("fp_mul", m_fp_mul, 0);
    chk("fp_exc", exc_valid, 1);
    chk("fp_exc_rob", exc_rob, 12);
    chk("fp_busy", busy, 0);
`endif
    step();
    chk("fp_exc_drop", exc_valid, 0);
    chk("fp_go_drop", m_go, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
# mul_sched

Issue scheduler for the shared fixed-latency integer/FP32 multiply unit. Arbitrates up to N_REQ requesters (integer and FP issue queues) round-robin onto the unit's single `go` port, one op per cycle. Checks a writeback-slot reservation before issue, and tracks in-flight ops in a shadow shift register so a pipeline flush squashes their completions. Sits between the issue queues and the multiplier; its outputs drive the multiplier inputs and qualify the multiplier's completion toward the PRF/ROB.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4)
- LAT, 4, multiplier latency from `go` to `complete` in cycles
- ROB_W, `LG_ROB_ENTRIES`, ROB pointer width
- PRF_W, `LG_PRF_ENTRIES`, PRF pointer width

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  N_REQ  per-requester op valid
- req_ready  out  N_REQ  per-requester grant; handshake = valid & ready at posedge
- req_op  in  N_REQ×7  {is_signed,is_high,is_mulw,fp_add,fp_sub,fp_mul,int_mul}
- req_src_a, req_src_b  in  N_REQ×`M_WIDTH`  operands
- req_rob  in  N_REQ×ROB_W;  req_prf  in  N_REQ×PRF_W
- slot_resv  in  1  another unit owns the writeback slot LAT+1 cycles ahead
- flush  in  1  synchronous squash of all in-flight and same-cycle ops
- m_go, m_is_signed, m_is_high, m_is_mulw, m_fp_add, m_fp_sub, m_fp_mul  out  1 each  registered multiplier controls
- m_src_a, m_src_b  out  `M_WIDTH`;  m_rob  out  ROB_W;  m_prf  out  PRF_W
- m_complete  in  1  multiplier completion
- wb_valid  out  1  qualified completion (m_complete & in-flight bit)
- exc_valid  out  1  unsupported-op exception pulse;  exc_rob  out  ROB_W
- busy  out  1  any op in flight;  inflight_cnt  out  $clog2(LAT+2)

## Operation
- Eligible = req_valid[i] & ~slot_resv & ~flush. At most one grant per cycle.
- Round-robin: search starts at rr_ptr; on grant, rr_ptr <= granted index + 1 (mod N_REQ); no grant -> unchanged. Flush does not move rr_ptr.
- Granted op is registered onto m_* next cycle, with m_go=1. Idle cycles: m_go=0, other m_* hold last value.
- Shadow vector sv[LAT:0]: sv[0] <= handshake; sv[i] <= sv[i-1]. wb_valid = m_complete & sv[LAT]. inflight_cnt = popcount(sv). busy = |sv.
- Flush: sv cleared to 0 at the edge; m_go of any op registered that edge forced 0; later m_complete is suppressed (wb_valid=0).
- m_complete=1 with sv[LAT]=0 -> wb_valid=0 (stale/flushed op; not an error).
- Exactly one of int_mul/fp_add/fp_sub/fp_mul must be set; the op-class encoding is passed through unchecked.

## Timing
- Reset (low): req_ready=0, m_go=0, all m_* = 0, wb_valid=0, exc_valid=0, exc_rob=0, busy=0, inflight_cnt=0, rr_ptr=0. Reset mid-operation discards everything in flight.
- req_ready is combinational from req_valid, slot_resv, flush and rr_ptr.
- Handshake at edge k -> m_go high in cycle k+1 -> wb_valid in cycle k+1+LAT.
- slot_resv sampled in handshake cycle k refers to writeback cycle k+1+LAT.
- Back-to-back: one issue per cycle sustained; inflight_cnt saturates at LAT+1 naturally.
- Flush and handshake in the same cycle: flush wins, req_ready=0.

## Configuration
- MUL_SCHED_FP_EN defined: fp_add/fp_sub/fp_mul ops issue normally.
- Undefined: an FP op is still granted (same arbitration), not forwarded (m_go stays 0, sv[0]=0), and exc_valid pulses one cycle later with exc_rob = its ROB pointer. m_fp_* are tied 0.

## Test plan
- Single int mul, req 0, rob=5, prf=9, at edge 10 -> m_go at cycle 11; with m_complete at cycle 15 (LAT=4), wb_valid=1 for one cycle.
- Both requesters valid continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; inflight_cnt reaches 5.
- slot_resv=1 with req 0 valid -> req_ready=0; next cycle slot_resv=0 -> grant; m_go exactly one cycle later.
- Issue 3 ops, assert flush 2 cycles after the first -> all 3 m_complete pulses yield wb_valid=0; busy=0 the cycle after flush.
- reset driven low mid-burst (asynchronously, between edges) -> all outputs 0 immediately; after release, rr_ptr=0, first grant to req 0.
- MUL_SCHED_FP_EN undefined, fp_mul op with rob=12 -> m_go stays 0, exc_valid=1 and exc_rob=12 in the following cycle; with the macro defined -> m_fp_mul=1, m_go=1.
